// File: rtl/ahblite_bus_arbiter.sv
// ahblite_bus_arbiter: two-master AHB-Lite arbiter placed ahead of the address decoder.
// The Cortex-M0 core (M0) and the PID accelerator's bus master (M1) share one system bus.
// M0 has fixed priority. M1 can take priority after STARVE_MAX denied request cycles.
// Fixed-length bursts (INCR4/8/16, WRAP4/8/16) are never split.
//
// Ports:
//   HCLK, HRESETn         bus clock, synchronous active-low reset
//   HREADY                transfer done from the slave mux (also seen by both masters)
//   Mx_HBUSREQ            bus request from master x
//   Mx_HTRANS/HADDR/...   address-phase signals from master x
//   Mx_HWDATA             write data from master x
//   Mx_HGRANT             master x owns the address bus
//   HADDR..HPROT          address phase muxed by the registered grant
//   HWDATA                write data muxed by the registered data-phase owner
//   HMASTER               current address-phase owner
//
// Optional feature (macro ARB_LOCK_EN): adds M0_HMASTLOCK/M1_HMASTLOCK inputs and the
// HMASTLOCK output. While the owner holds its lock, arbitration is suppressed.
module ahblite_bus_arbiter #(
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned STARVE_MAX     = 15,
    parameter int unsigned CNT_W          = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HREADY,
`ifdef ARB_LOCK_EN
    input  logic        M0_HMASTLOCK,
    input  logic        M1_HMASTLOCK,
    output logic        HMASTLOCK,
`endif
    input  logic        M0_HBUSREQ,
    input  logic [1:0]  M0_HTRANS,
    input  logic [31:0] M0_HADDR,
    input  logic        M0_HWRITE,
    input  logic [2:0]  M0_HSIZE,
    input  logic [2:0]  M0_HBURST,
    input  logic [3:0]  M0_HPROT,
    input  logic [31:0] M0_HWDATA,
    input  logic        M1_HBUSREQ,
    input  logic [1:0]  M1_HTRANS,
    input  logic [31:0] M1_HADDR,
    input  logic        M1_HWRITE,
    input  logic [2:0]  M1_HSIZE,
    input  logic [2:0]  M1_HBURST,
    input  logic [3:0]  M1_HPROT,
    input  logic [31:0] M1_HWDATA,
    output logic        M0_HGRANT,
    output logic        M1_HGRANT,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    output logic        HMASTER
);

    localparam logic             DefMaster = 1'(DEFAULT_MASTER);
    localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);
    localparam logic [1:0]       TransNonseq = 2'b10;
    localparam logic [1:0]       TransSeq    = 2'b11;

    logic             gnt;        // address-phase owner (1 = M1)
    logic             dsel;       // data-phase owner
    logic [CNT_W-1:0] beat_cnt;   // beats left in the owner's fixed-length burst
    logic [CNT_W-1:0] starve_cnt; // consecutive denied M1 request cycles

    logic [1:0]       own_htrans;
    logic [2:0]       own_hburst;
    logic             burst_fixed;
    logic             burst_locked;
    logic             arb_point;
    logic             gnt_next;
    logic [CNT_W-1:0] beat_load;

    // Address phase follows the registered grant only, so there is no path from HBUSREQ.
    assign HADDR     = gnt ? M1_HADDR  : M0_HADDR;
    assign HTRANS    = gnt ? M1_HTRANS : M0_HTRANS;
    assign HWRITE    = gnt ? M1_HWRITE : M0_HWRITE;
    assign HSIZE     = gnt ? M1_HSIZE  : M0_HSIZE;
    assign HBURST    = gnt ? M1_HBURST : M0_HBURST;
    assign HPROT     = gnt ? M1_HPROT  : M0_HPROT;
    assign HWDATA    = dsel ? M1_HWDATA : M0_HWDATA;
    assign HMASTER   = gnt;
    assign M0_HGRANT = ~gnt;
    assign M1_HGRANT = gnt;

    assign own_htrans = HTRANS;
    assign own_hburst = HBURST;

    // SINGLE (000) and INCR (001) are the only bursts without a fixed length.
    assign burst_fixed  = (own_hburst[2:1] != 2'b00);
    assign burst_locked = (beat_cnt != '0) || ((own_htrans == TransNonseq) && burst_fixed);

`ifdef ARB_LOCK_EN
    assign HMASTLOCK = gnt ? M1_HMASTLOCK : M0_HMASTLOCK;
    assign arb_point = HREADY && !burst_locked && !HMASTLOCK;
`else
    assign arb_point = HREADY && !burst_locked;
`endif

    always_comb begin
        gnt_next = DefMaster;
        if ((starve_cnt == StarveMax) && M1_HBUSREQ) begin
            gnt_next = 1'b1;
        end else if (M0_HBUSREQ) begin
            gnt_next = 1'b0;
        end else if (M1_HBUSREQ) begin
            gnt_next = 1'b1;
        end
    end

    // Remaining beats after the first one of a fixed-length burst.
    always_comb begin
        beat_load = '0;
        unique case (own_hburst)
            3'b010, 3'b011: beat_load = CNT_W'(3);
            3'b100, 3'b101: beat_load = CNT_W'(7);
            3'b110, 3'b111: beat_load = CNT_W'(15);
            default:        beat_load = '0;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            gnt        <= DefMaster;
            dsel       <= DefMaster;
            beat_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            if (HREADY) begin
                dsel <= gnt;
            end
            if (arb_point) begin
                gnt <= gnt_next;
            end

            if (HREADY && (own_htrans == TransNonseq)) begin
                beat_cnt <= beat_load;
            end else if (HREADY && (own_htrans == TransSeq) && (beat_cnt != '0)) begin
                beat_cnt <= beat_cnt - 1'b1;
            end

            if (gnt || !M1_HBUSREQ) begin
                starve_cnt <= '0;
            end else if (starve_cnt < StarveMax) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahblite_bus_arbiter.sv
// Self-checking bench for ahblite_bus_arbiter. Expected values are queued when a cycle's
// stimulus is driven and compared once that cycle's outputs have settled. A second
// instance with DEFAULT_MASTER=1 shares the inputs and covers the parking behaviour.
module tb_ahblite_bus_arbiter;

    localparam int S_GNT0    = 0;
    localparam int S_GNT1    = 1;
    localparam int S_HMASTER = 2;
    localparam int S_HADDR   = 3;
    localparam int S_HTRANS  = 4;
    localparam int S_HWDATA  = 5;
    localparam int S_STARVE  = 6;
    localparam int S_BEAT    = 7;
    localparam int P_MASTER  = 8;
    localparam int P_HTRANS  = 9;
    localparam int S_LOCK    = 10;

    localparam logic [31:0] D0 = 32'hA0A0_A0A0;
    localparam logic [31:0] D1 = 32'hB1B1_B1B1;

    logic        HCLK = 1'b0;
    logic        HRESETn, HREADY;
    logic        M0_HMASTLOCK, M1_HMASTLOCK;
    logic        M0_HBUSREQ, M0_HWRITE, M1_HBUSREQ, M1_HWRITE;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic [31:0] M0_HADDR, M0_HWDATA, M1_HADDR, M1_HWDATA;
    logic [2:0]  M0_HSIZE, M0_HBURST, M1_HSIZE, M1_HBURST;
    logic [3:0]  M0_HPROT, M1_HPROT;

    logic        M0_HGRANT, M1_HGRANT, HWRITE, HMASTER, HMASTLOCK;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    logic        p_m0_hgrant, p_m1_hgrant, p_hwrite, p_hmaster, p_hmastlock;
    logic [31:0] p_haddr, p_hwdata;
    logic [1:0]  p_htrans;
    logic [2:0]  p_hsize, p_hburst;
    logic [3:0]  p_hprot;

    always #5 HCLK = ~HCLK;

    ahblite_bus_arbiter dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY),
`ifdef ARB_LOCK_EN
        .M0_HMASTLOCK(M0_HMASTLOCK), .M1_HMASTLOCK(M1_HMASTLOCK), .HMASTLOCK(HMASTLOCK),
`endif
        .M0_HBUSREQ(M0_HBUSREQ), .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR),
        .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST),
        .M0_HPROT(M0_HPROT), .M0_HWDATA(M0_HWDATA),
        .M1_HBUSREQ(M1_HBUSREQ), .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR),
        .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST),
        .M1_HPROT(M1_HPROT), .M1_HWDATA(M1_HWDATA),
        .M0_HGRANT(M0_HGRANT), .M1_HGRANT(M1_HGRANT),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HMASTER(HMASTER)
    );

    ahblite_bus_arbiter #(.DEFAULT_MASTER(1)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY),
`ifdef ARB_LOCK_EN
        .M0_HMASTLOCK(M0_HMASTLOCK), .M1_HMASTLOCK(M1_HMASTLOCK), .HMASTLOCK(p_hmastlock),
`endif
        .M0_HBUSREQ(M0_HBUSREQ), .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR),
        .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST),
        .M0_HPROT(M0_HPROT), .M0_HWDATA(M0_HWDATA),
        .M1_HBUSREQ(M1_HBUSREQ), .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR),
        .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST),
        .M1_HPROT(M1_HPROT), .M1_HWDATA(M1_HWDATA),
        .M0_HGRANT(p_m0_hgrant), .M1_HGRANT(p_m1_hgrant),
        .HADDR(p_haddr), .HTRANS(p_htrans), .HWRITE(p_hwrite), .HSIZE(p_hsize),
        .HBURST(p_hburst), .HPROT(p_hprot), .HWDATA(p_hwdata), .HMASTER(p_hmaster)
    );

    typedef struct {
        int          sig;
        logic [31:0] exp;
        string       tag;
    } sb_item_t;

    sb_item_t sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_GNT0:    return {31'b0, M0_HGRANT};
            S_GNT1:    return {31'b0, M1_HGRANT};
            S_HMASTER: return {31'b0, HMASTER};
            S_HADDR:   return HADDR;
            S_HTRANS:  return {30'b0, HTRANS};
            S_HWDATA:  return HWDATA;
            S_STARVE:  return 32'(dut0.starve_cnt);
            S_BEAT:    return 32'(dut0.beat_cnt);
            P_MASTER:  return {31'b0, p_hmaster};
            P_HTRANS:  return {30'b0, p_htrans};
            S_LOCK:    return {31'b0, HMASTLOCK};
            default:   return 'x;
        endcase
    endfunction

    task automatic push(input int sig, input logic [31:0] exp, input string tag);
        sb_item_t it;
        it.sig = sig;
        it.exp = exp;
        it.tag = tag;
        sb.push_back(it);
    endtask

    // Settle, compare everything queued for this cycle, then end the cycle.
    task automatic cycle();
        sb_item_t it;
        #1;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            check(it.tag, observe(it.sig), it.exp);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_all();
        HREADY = 1'b1;
        M0_HMASTLOCK = 1'b0; M1_HMASTLOCK = 1'b0;
        M0_HBUSREQ = 1'b0; M0_HTRANS = 2'b00; M0_HADDR = 32'h0; M0_HWRITE = 1'b0;
        M0_HSIZE = 3'b010; M0_HBURST = 3'b000; M0_HPROT = 4'h3; M0_HWDATA = D0;
        M1_HBUSREQ = 1'b0; M1_HTRANS = 2'b00; M1_HADDR = 32'h0; M1_HWRITE = 1'b1;
        M1_HSIZE = 3'b010; M1_HBURST = 3'b000; M1_HPROT = 4'h1; M1_HWDATA = D1;
    endtask

    task automatic do_reset();
        idle_all();
        HRESETn = 1'b0;
        cycle();
        cycle();
        HRESETn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset while both masters request.
        idle_all();
        HRESETn = 1'b0;
        M0_HBUSREQ = 1'b1;
        M1_HBUSREQ = 1'b1;
        cycle();
        cycle();
        push(S_HMASTER, 0, "rst_hmaster");
        push(S_GNT0, 1, "rst_m0_grant");
        push(S_GNT1, 0, "rst_m1_grant");
        push(S_HWDATA, D0, "rst_hwdata");
        push(S_STARVE, 0, "rst_starve");
        push(S_BEAT, 0, "rst_beat");
        push(P_MASTER, 1, "rst_park1_hmaster");
        cycle();

        // Only M1 requests.
        do_reset();
        M1_HBUSREQ = 1'b1;
        push(S_GNT1, 0, "m1only_gnt_c0");
        cycle();
        M1_HTRANS = 2'b10;
        M1_HADDR = 32'h2000_0040;
        push(S_GNT1, 1, "m1only_gnt_c1");
        push(S_GNT0, 0, "m1only_m0gnt_c1");
        push(S_HADDR, 32'h2000_0040, "m1only_haddr");
        push(S_HTRANS, 2, "m1only_htrans");
        push(S_HWDATA, D0, "m1only_hwdata_lag");
        push(S_STARVE, 1, "m1only_starve_c1");
        cycle();
        M1_HTRANS = 2'b00;
        push(S_HWDATA, D1, "m1only_hwdata_c2");
        push(S_STARVE, 0, "m1only_starve_c2");
        cycle();

        // M1 INCR4 with a 2-cycle stall on beat 2; M0 requests during beat 1.
        do_reset();
        M1_HBUSREQ = 1'b1;
        cycle();
        M1_HTRANS = 2'b10; M1_HBURST = 3'b011; M1_HADDR = 32'h2000_0000;
        push(S_GNT1, 1, "incr4_gnt_b0");
        cycle();
        M1_HTRANS = 2'b11; M1_HADDR = 32'h2000_0004; M0_HBUSREQ = 1'b1;
        push(S_BEAT, 3, "incr4_beat_b1");
        push(S_GNT1, 1, "incr4_gnt_b1");
        cycle();
        M1_HADDR = 32'h2000_0008; HREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(S_HMASTER, 1, "incr4_stall_hmaster");
            push(S_HADDR, 32'h2000_0008, "incr4_stall_haddr");
            cycle();
        end
        HREADY = 1'b1;
        push(S_BEAT, 2, "incr4_beat_b2");
        push(S_HMASTER, 1, "incr4_hmaster_b2");
        cycle();
        M1_HADDR = 32'h2000_000C;
        push(S_BEAT, 1, "incr4_beat_b3");
        push(S_HMASTER, 1, "incr4_hmaster_b3");
        cycle();
        M1_HTRANS = 2'b00; M1_HBURST = 3'b000;
        push(S_BEAT, 0, "incr4_beat_done");
        push(S_HMASTER, 1, "incr4_hmaster_arb");
        push(S_HWDATA, D1, "incr4_hwdata_arb");
        cycle();
        M0_HTRANS = 2'b10; M0_HADDR = 32'h0000_0100;
        push(S_GNT0, 1, "incr4_m0_granted");
        push(S_HADDR, 32'h0000_0100, "incr4_m0_haddr");
        push(S_HWDATA, D1, "incr4_dsel_lag");
        cycle();
        M0_HTRANS = 2'b00;
        push(S_HWDATA, D0, "incr4_dsel_m0");
        push(S_STARVE, 1, "incr4_starve");
        cycle();

        // Starvation override: M0 streams SINGLE transfers while M1 requests.
        do_reset();
        M0_HBUSREQ = 1'b1; M0_HTRANS = 2'b10; M0_HBURST = 3'b000;
        M1_HBUSREQ = 1'b1;
        for (int k = 0; k < 16; k++) begin
            push(S_STARVE, 32'(k), "starve_count");
            push(S_GNT0, 1, "starve_m0_holds");
            cycle();
        end
        push(S_GNT1, 1, "starve_m1_granted");
        push(S_STARVE, 15, "starve_saturated");
        cycle();
        push(S_GNT1, 1, "starve_m1_holds");
        push(S_STARVE, 0, "starve_cleared");
        cycle();
        push(S_GNT0, 1, "starve_m0_back");
        cycle();

        // Parking on DEFAULT_MASTER=1 (second instance).
        do_reset();
        M0_HBUSREQ = 1'b1;
        push(P_MASTER, 1, "park_start");
        cycle();
        M0_HBUSREQ = 1'b0;
        push(P_MASTER, 0, "park_m0_granted");
        cycle();
        M0_HTRANS = 2'b10;
        push(P_MASTER, 1, "park_on_m1");
        push(P_HTRANS, 0, "park_htrans_idle");
        push(S_HMASTER, 0, "park_on_m0_default0");
        cycle();
        M0_HTRANS = 2'b00;
        push(P_MASTER, 1, "park_holds");
        cycle();

`ifdef ARB_LOCK_EN
        // Locked SINGLE transfers from M0 keep the bus away from M1.
        do_reset();
        M0_HBUSREQ = 1'b1; M0_HMASTLOCK = 1'b1; M0_HTRANS = 2'b10;
        M1_HBUSREQ = 1'b1;
        for (int k = 0; k < 3; k++) begin
            M0_HADDR = 32'h0000_0200 + 32'(4 * k);
            push(S_GNT0, 1, "lock_m0_holds");
            push(S_LOCK, 1, "lock_hmastlock");
            cycle();
        end
        M0_HBUSREQ = 1'b0; M0_HMASTLOCK = 1'b0; M0_HTRANS = 2'b00;
        push(S_GNT0, 1, "lock_drop_cycle");
        push(S_LOCK, 0, "lock_released");
        cycle();
        push(S_GNT1, 1, "lock_m1_granted");
        cycle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
